hash_verify_ctrl: RTL and testbench
===================================

// Module: hash_verify_ctrl
// PURPOSE
//  Consumer side of the 8-bit-lane hash datapath. Accepts {message, expected digest}, starts the hash core,
//  waits for done, compares digest to expected, returns a match/timeout verdict via valid/ready.
//  Sits between the host request port and the hash core controller; keeps pass/fail statistics.
// PARAMETERS
//  MSG_W    32  message word width; must equal core msg width
//  DIG_W    32  digest width; {A,B,C,D} = 4 x 8 bits
//  TIMEOUT  80  max WAIT cycles for hash_done (core needs 64 rounds + overhead); >= 2
//  CNT_W    16  width of pass/fail statistic counters
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      synchronous, active-low reset
//  in_valid     in   1      request valid
//  in_ready     out  1      request accepted when in_valid & in_ready
//  in_msg       in   MSG_W  message to hash
//  in_expect    in   DIG_W  expected digest
//  hash_start   out  1      one-cycle start pulse to hash core
//  hash_msg     out  MSG_W  message to core; held stable from start until done/timeout
//  hash_done    in   1      core completion strobe
//  hash_digest  in   DIG_W  core digest, valid in the cycle hash_done=1
//  res_valid    out  1      verdict valid; held until res_ready
//  res_ready    in   1      verdict consumed when res_valid & res_ready
//  res_match    out  1      1 = digest equals expected
//  res_timeout  out  1      1 = core never signalled done
//  res_digest   out  DIG_W  captured digest (0 on timeout)
//  pass_cnt     out  CNT_W  saturating count of delivered matches
//  fail_cnt     out  CNT_W  saturating count of delivered mismatches + timeouts
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE; all outputs 0 except in_ready=1 afterwards; counters 0; captures 0.
//  FSM states: IDLE, START, WAIT, CMP, RESP.
//   IDLE : in_ready=1. On in_valid -> capture in_msg/in_expect, go START.
//   START: in_ready=0, hash_start=1 (exactly one cycle), timer<=0, go WAIT.
//   WAIT : timer++ each cycle. hash_done=1 -> capture hash_digest, go CMP.
//          Else timer==TIMEOUT-1 -> res_timeout<=1, res_match<=0, res_digest<=0, go RESP.
//          Done and timeout in same cycle: done wins.
//   CMP  : res_match <= (digest_q == expect_q); res_timeout<=0; go RESP.
//   RESP : res_valid=1, res_* stable. On res_ready -> bump pass_cnt (match) or fail_cnt, go IDLE.
//  Latency: accept at edge k -> hash_start high cycle k+1; done seen cycle d -> res_valid high at cycle d+2.
//  Back-to-back: in_ready returns the cycle after the result handshake; no request overlap (1 in flight).
//  hash_done outside WAIT is ignored (no capture, no state change).
//  in_msg/in_expect changes after acceptance have no effect; hash_msg driven from captured register.
//  Counters saturate at all-ones; no wrap. Timer width = clog2(TIMEOUT).
//  res_valid low in every state except RESP; res_ready outside RESP ignored.
//  Reset mid-operation: abort to IDLE, no counter update, hash_start low; core is reset by same rst.
// STRUCTURE
//  Shared header hash_defs.vh: FSM state encodings, DIG_W/MSG_W defaults, core IV bytes a0..d0,
//  core round count (64) used to derive TIMEOUT default.
//  One sub-module: sat_counter #(CNT_W) (enable, sync active-low reset, saturating) x2 for pass/fail.
//  FSM, timer, capture regs and comparator stay in this module.
// TESTING (bench uses a behavioural core stub with programmable latency and digest)
//  1 Reset: rst=0 3 cycles -> in_ready=1, res_valid=0, hash_start=0, pass_cnt=fail_cnt=0.
//  2 Match: msg=32'h01234567, expect=32'hDEADBEEF, stub done after 66 cyc with 32'hDEADBEEF
//    -> single start pulse, res_valid 2 cyc after done, res_match=1, pass_cnt=1.
//  3 Mismatch: same, stub digest 32'hDEADBEEE -> res_match=0, res_digest=32'hDEADBEEE, fail_cnt=1.
//  4 Timeout: stub never done -> res_valid after TIMEOUT(80) WAIT cycles, res_timeout=1, digest=0, fail_cnt++.
//    Variant: done on cycle 80 exactly -> treated as done, res_timeout=0.
//  5 Backpressure/stray done: res_ready=0 for 10 cyc -> outputs stable, in_ready=0; hash_done pulsed in
//    IDLE/RESP -> no change; in_msg toggled after accept -> hash_msg unchanged.
//  6 Reset mid-WAIT and saturation: rst=0 at WAIT cycle 20 -> IDLE, counters 0; CNT_W=2 with 5 matches -> pass_cnt=3.

Source files
------------

// File: rtl/hash_verify_ctrl_pkg.sv
// Shared definitions for the hash verify controller: FSM encoding and core-derived defaults.
// No logic; constants and types only.
// Timeout default is derived from the core round count plus handshake overhead.
package hash_verify_ctrl_pkg;

    localparam int MSG_W_DEF      = 32;
    localparam int DIG_W_DEF      = 32;
    localparam int CNT_W_DEF      = 16;

    // Core runs one round per cycle; overhead covers its own load/unload cycles.
    localparam int CORE_ROUNDS    = 64;
    localparam int CORE_OVERHEAD  = 16;
    localparam int TIMEOUT_DEF    = CORE_ROUNDS + CORE_OVERHEAD;

    // Core initial value bytes {A,B,C,D}
    localparam logic [7:0] IV_A0 = 8'h67;
    localparam logic [7:0] IV_B0 = 8'hEF;
    localparam logic [7:0] IV_C0 = 8'h98;
    localparam logic [7:0] IV_D0 = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CMP   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Digest the core would report for an empty round schedule.
    function automatic logic [31:0] core_iv();
        return {IV_A0, IV_B0, IV_C0, IV_D0};
    endfunction

endpackage

// File: rtl/hash_verify_ctrl_if.sv
// Request/verdict channel between host and hash verify controller.
// Pure wiring, no latency.
// Both channels are valid/ready; producer holds payload until the handshake.
interface hash_verify_ctrl_if
    import hash_verify_ctrl_pkg::*;
#(
    parameter int MSG_W = MSG_W_DEF,
    parameter int DIG_W = DIG_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [MSG_W-1:0] in_msg;
    logic [DIG_W-1:0] in_expect;
    logic             res_valid;
    logic             res_ready;
    logic             res_match;
    logic             res_timeout;
    logic [DIG_W-1:0] res_digest;

    // Host side: issues requests, consumes verdicts
    modport master (
        output in_valid, in_msg, in_expect, res_ready,
        input  in_ready, res_valid, res_match, res_timeout, res_digest
    );

    // Controller side: accepts requests, produces verdicts
    modport slave (
        input  in_valid, in_msg, in_expect, res_ready,
        output in_ready, res_valid, res_match, res_timeout, res_digest
    );

endinterface

// File: rtl/hash_verify_ctrl_sat_counter.sv
// Saturating up-counter used for pass/fail statistics.
// Increments on the edge after en; value visible next cycle.
// No backpressure; holds at all-ones instead of wrapping.
module hash_verify_ctrl_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Count enabled events, stick at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hash_verify_ctrl.sv
// Hash verify controller: starts the core on a request, compares its digest to the expected one, returns a verdict.
// Latency: accept edge k -> hash_start in cycle k+1; done in cycle d -> res_valid in cycle d+2; timeout after TIMEOUT wait cycles.
// One request in flight; in_ready low from accept until the verdict is consumed; verdict held while res_ready is low.
module hash_verify_ctrl
    import hash_verify_ctrl_pkg::*;
#(
    parameter int MSG_W   = MSG_W_DEF,
    parameter int DIG_W   = DIG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    hash_verify_ctrl_if.slave bus,
    output logic             hash_start,
    output logic [MSG_W-1:0] hash_msg,
    input  logic             hash_done,
    input  logic [DIG_W-1:0] hash_digest,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [MSG_W-1:0] msg_q;
    logic [DIG_W-1:0] expect_q;
    logic [DIG_W-1:0] digest_q;
    logic [TMR_W-1:0] timer_q;
    logic             timer_exp;
    logic             res_match_q;
    logic             res_timeout_q;
    logic [DIG_W-1:0] res_digest_q;
    logic             pass_en;
    logic             fail_en;

    // Last permitted wait cycle; done in this same cycle still takes priority
    assign timer_exp = (timer_q == TMR_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.in_valid) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (hash_done)      state_d = ST_CMP;
                else if (timer_exp) state_d = ST_RESP;
            end
            ST_CMP:   state_d = ST_RESP;
            ST_RESP:  if (bus.res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs and statistic strobes
    always_comb begin
        bus.in_ready  = 1'b0;
        hash_start    = 1'b0;
        bus.res_valid = 1'b0;
        pass_en       = 1'b0;
        fail_en       = 1'b0;
        case (state_q)
            ST_IDLE:  bus.in_ready = 1'b1;
            ST_START: hash_start   = 1'b1;
            ST_RESP: begin
                bus.res_valid = 1'b1;
                pass_en       = bus.res_ready &  res_match_q;
                fail_en       = bus.res_ready & ~res_match_q;
            end
            default: ;
        endcase
    end

    // Capture registers, wait timer and verdict registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            msg_q         <= '0;
            expect_q      <= '0;
            digest_q      <= '0;
            timer_q       <= '0;
            res_match_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            res_digest_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        msg_q    <= bus.in_msg;
                        expect_q <= bus.in_expect;
                    end
                end
                ST_START: timer_q <= '0;
                ST_WAIT: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (hash_done) begin
                        digest_q <= hash_digest;
                    end else if (timer_exp) begin
                        res_timeout_q <= 1'b1;
                        res_match_q   <= 1'b0;
                        res_digest_q  <= '0;
                    end
                end
                ST_CMP: begin
                    res_match_q   <= (digest_q == expect_q);
                    res_timeout_q <= 1'b0;
                    res_digest_q  <= digest_q;
                end
                default: ;
            endcase
        end
    end

    assign hash_msg        = msg_q;
    assign bus.res_match   = res_match_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.res_digest  = res_digest_q;

    hash_verify_ctrl_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .en  (pass_en),
        .cnt (pass_cnt)
    );

    hash_verify_ctrl_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .en  (fail_en),
        .cnt (fail_cnt)
    );

endmodule

// File: tb/tb_hash_verify_ctrl.sv
// Bench for hash_verify_ctrl: behavioural core stub with programmable latency/digest, verdict model.
// Second instance with 2-bit counters runs in lockstep on the same stimulus.
// Host drives at negedge-aligned points and samples outputs at negedge.
module tb_hash_verify_ctrl;

    localparam int TO = 80;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hash_verify_ctrl_if #(.MSG_W(32), .DIG_W(32)) hv ();
    hash_verify_ctrl_if #(.MSG_W(32), .DIG_W(32)) hv2 ();

    logic        hash_start, hash_start2;
    logic [31:0] hash_msg, hash_msg2;
    logic        hash_done;
    logic [31:0] hash_digest;
    logic [15:0] pass_cnt, fail_cnt;
    logic [1:0]  pass2, fail2;

    assign hv2.in_valid  = hv.in_valid;
    assign hv2.in_msg    = hv.in_msg;
    assign hv2.in_expect = hv.in_expect;
    assign hv2.res_ready = hv.res_ready;

    hash_verify_ctrl #(.MSG_W(32), .DIG_W(32), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(hv),
        .hash_start(hash_start), .hash_msg(hash_msg),
        .hash_done(hash_done), .hash_digest(hash_digest),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    hash_verify_ctrl #(.MSG_W(32), .DIG_W(32), .TIMEOUT(TO), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(hv2),
        .hash_start(hash_start2), .hash_msg(hash_msg2),
        .hash_done(hash_done), .hash_digest(hash_digest),
        .pass_cnt(pass2), .fail_cnt(fail2)
    );

    // Core stub: done pulses stub_lat cycles after the start pulse cycle
    int          stub_lat = 1;
    bit          stub_never = 1'b0;
    logic [31:0] stub_dig = '0;
    logic        stray_done = 1'b0;
    logic        armed;
    int          cnt;

    always @(posedge clk) begin
        if (!rst) begin
            armed <= 1'b0;
            cnt   <= 0;
        end else if (hash_start) begin
            armed <= 1'b1;
            cnt   <= 1;
        end else if (armed) begin
            if (!stub_never && cnt == stub_lat) armed <= 1'b0;
            cnt <= cnt + 1;
        end
    end

    assign hash_done   = stray_done | (armed && !stub_never && cnt == stub_lat);
    assign hash_digest = stub_dig;

    int n_chk = 0;
    int n_err = 0;
    int m_pass = 0;
    int m_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_pass16"}, 64'(pass_cnt), 64'(sat(m_pass, 65535)));
        chk({tag, "_fail16"}, 64'(fail_cnt), 64'(sat(m_fail, 65535)));
        chk({tag, "_pass2"},  64'(pass2),    64'(sat(m_pass, 3)));
        chk({tag, "_fail2"},  64'(fail2),    64'(sat(m_fail, 3)));
    endtask

    // One request end to end: verdict, timing, hold of outputs under backpressure
    task automatic run_txn(input logic [31:0] msg, input logic [31:0] exp, input int lat,
                           input bit never, input logic [31:0] dig, input int bp, input bit early_rdy);
        bit   e_to, e_match, got, msg_bad, rdy_bad, hold_bad;
        logic [31:0] e_dig;
        int   e_cyc, cyc, starts, starts2, start_cyc;

        e_to    = never || (lat > TO);
        e_match = !e_to && (dig == exp);
        e_dig   = e_to ? 32'h0 : dig;
        e_cyc   = e_to ? TO + 2 : lat + 3;

        stub_lat   = lat;
        stub_never = never;
        stub_dig   = dig;

        @(negedge clk);
        chk("idle_in_ready", 64'(hv.in_ready), 64'd1);
        hv.in_valid  = 1'b1;
        hv.in_msg    = msg;
        hv.in_expect = exp;
        @(posedge clk);
        #1;
        hv.in_valid  = 1'b0;
        hv.in_msg    = $urandom;
        hv.in_expect = $urandom;
        if (early_rdy) hv.res_ready = 1'b1;

        cyc = 0; starts = 0; starts2 = 0; start_cyc = 0;
        got = 1'b0; msg_bad = 1'b0; rdy_bad = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (hash_start) begin starts++; start_cyc = cyc; end
            if (hash_start2) starts2++;
            if (hash_msg !== msg || hash_msg2 !== msg) msg_bad = 1'b1;
            if (hv.in_ready !== 1'b0) rdy_bad = 1'b1;
            if (hv.res_valid === 1'b1) got = 1'b1;
        end

        chk("resp_seen",     64'(got),       64'd1);
        chk("start_count",   64'(starts),    64'd1);
        chk("start_count2",  64'(starts2),   64'd1);
        chk("start_cycle",   64'(start_cyc), 64'd1);
        chk("resp_latency",  64'(cyc),       64'(e_cyc));
        chk("hash_msg_hold", 64'(msg_bad),   64'd0);
        chk("busy_in_ready", 64'(rdy_bad),   64'd0);
        chk("res_match",     64'(hv.res_match),   64'(e_match));
        chk("res_timeout",   64'(hv.res_timeout), 64'(e_to));
        chk("res_digest",    64'(hv.res_digest),  64'(e_dig));
        chk("res_match2",    64'(hv2.res_match),  64'(e_match));

        if (!early_rdy && bp > 0) begin
            hold_bad = 1'b0;
            for (int i = 0; i < bp; i++) begin
                if (i == bp / 2) begin
                    stub_dig   = ~dig;
                    stray_done = 1'b1;
                end
                @(negedge clk);
                stray_done = 1'b0;
                if (hv.res_valid !== 1'b1 || hv.in_ready !== 1'b0 || hv.res_match !== e_match ||
                    hv.res_timeout !== e_to || hv.res_digest !== e_dig)
                    hold_bad = 1'b1;
            end
            chk("bp_hold", 64'(hold_bad), 64'd0);
        end

        hv.res_ready = 1'b1;
        @(posedge clk);
        #1;
        hv.res_ready = 1'b0;
        if (e_match) m_pass++; else m_fail++;

        @(negedge clk);
        chk("post_in_ready",  64'(hv.in_ready),  64'd1);
        chk("post_res_valid", 64'(hv.res_valid), 64'd0);
        chk_counters("post");
    endtask

    // hash_done while idle must not disturb anything
    task automatic stray_idle_done();
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        chk("stray_in_ready",  64'(hv.in_ready),  64'd1);
        chk("stray_res_valid", 64'(hv.res_valid), 64'd0);
        chk("stray_start",     64'(hash_start),   64'd0);
    endtask

    initial begin
        logic [31:0] e, m, d;
        int          l;
        bit          nv, er;
        int          b;

        hv.in_valid  = 1'b0;
        hv.in_msg    = '0;
        hv.in_expect = '0;
        hv.res_ready = 1'b0;

        // Reset
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(hv.in_ready),  64'd1);
        chk("rst_res_valid", 64'(hv.res_valid), 64'd0);
        chk("rst_start",     64'(hash_start),   64'd0);
        chk("rst_hash_msg",  64'(hash_msg),     64'd0);
        chk_counters("rst");
        rst = 1'b1;

        // Directed: match, mismatch, timeout, boundary done/timeout
        run_txn(32'h01234567, 32'hDEADBEEF, 66, 1'b0, 32'hDEADBEEF, 0, 1'b0);
        run_txn(32'h01234567, 32'hDEADBEEF, 66, 1'b0, 32'hDEADBEEE, 0, 1'b0);
        run_txn(32'h89ABCDEF, 32'h12345678, 0,  1'b1, 32'h12345678, 0, 1'b0);
        run_txn(32'h89ABCDEF, 32'h12345678, TO, 1'b0, 32'h12345678, 0, 1'b0);
        run_txn(32'h89ABCDEF, 32'h12345678, TO + 1, 1'b0, 32'h12345678, 0, 1'b0);
        run_txn(32'hCAFEF00D, 32'h0BADF00D, 1,  1'b0, 32'h0BADF00D, 0, 1'b0);

        // Backpressure with stray done in RESP and IDLE
        run_txn(32'h5A5A5A5A, 32'hA5A5A5A5, 10, 1'b0, 32'hA5A5A5A5, 10, 1'b0);
        stray_idle_done();

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            e  = $urandom;
            m  = $urandom;
            l  = $urandom_range(90, 1);
            nv = ($urandom_range(7, 0) == 0);
            d  = $urandom_range(1, 0) ? e : (e ^ (32'h1 << $urandom_range(31, 0)));
            b  = $urandom_range(4, 0);
            er = (b == 0) && $urandom_range(1, 0);
            run_txn(m, e, l, nv, d, b, er);
            if (t % 10 == 3) stray_idle_done();
        end

        // Reset in the middle of WAIT
        stub_never = 1'b1;
        @(negedge clk);
        hv.in_valid  = 1'b1;
        hv.in_msg    = 32'h13572468;
        hv.in_expect = 32'h0;
        @(posedge clk);
        #1;
        hv.in_valid = 1'b0;
        repeat (21) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        m_pass = 0;
        m_fail = 0;
        chk("midrst_in_ready",  64'(hv.in_ready),  64'd1);
        chk("midrst_res_valid", 64'(hv.res_valid), 64'd0);
        chk("midrst_start",     64'(hash_start),   64'd0);
        chk_counters("midrst");
        rst = 1'b1;

        // Saturation of the 2-bit instance
        for (int t = 0; t < 5; t++) begin
            e = $urandom;
            run_txn($urandom, e, $urandom_range(10, 1), 1'b0, e, 0, 1'b0);
        end
        chk("sat_pass2",  64'(pass2),    64'd3);
        chk("sat_pass16", 64'(pass_cnt), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
